// File: rtl/aes_csr_pkg.sv
// Shared types and constants for the AES CSR request bridge.
package aes_csr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } aes_csr_bridge_state_e;

  localparam logic [31:0] AES_CSR_ADDR_LIMIT = 32'h0000_0100;
  localparam logic [1:0]  AES_CSR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/aes_csr_req_bridge.sv
// Turns a valid/ready CSR request into a one-cycle access strobe and returns
// read data / error on a valid/ready response channel, one request at a time.
module aes_csr_req_bridge
  import aes_csr_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(AES_CSR_ADDR_LIMIT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  acc_en_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  if (RD_LATENCY > 3) begin : g_bad_rd_latency
    $error("aes_csr_req_bridge: RD_LATENCY must be in 0..3");
  end

  localparam logic [1:0] LAT_LOAD = (RD_LATENCY == 0) ? 2'd0 : 2'(RD_LATENCY - 1);

  aes_csr_bridge_state_e state_reg;
  logic [1:0]            cnt_reg;
  logic                  write_reg;
  logic                  req_ready_reg;
  logic                  acc_en_reg;
  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic                  illegal;

  assign illegal = (|(req_addr_i[1:0] & AES_CSR_ALIGN_MASK)) || (req_addr_i >= ADDR_LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      write_reg     <= 1'b0;
      req_ready_reg <= 1'b0;
      acc_en_reg    <= 1'b0;
      wr_en_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      acc_en_reg <= 1'b0;
      wr_en_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid_i && req_ready_reg) begin
            write_reg     <= req_write_i;
            addr_reg      <= req_addr_i;
            wdata_reg     <= req_wdata_i;
            req_ready_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            if (illegal) begin
              // Rejected requests skip the access port entirely.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end else begin
              state_reg   <= ACCESS;
              acc_en_reg  <= 1'b1;
              wr_en_reg   <= req_write_i;
              rsp_err_reg <= 1'b0;
            end
          end else begin
            req_ready_reg <= 1'b1;
          end
        end
        ACCESS: begin
          if (write_reg) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else if (RD_LATENCY == 0) begin
            rsp_rdata_reg <= rdata_i;
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg   <= LAT_LOAD;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 2'd0) begin
            rsp_rdata_reg <= rdata_i;
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_reg;
  assign acc_en_o    = acc_en_reg;
  assign wr_en_o     = wr_en_reg;
  assign addr_o      = addr_reg;
  assign wdata_o     = wdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_aes_csr_req_bridge.sv
// Bench for aes_csr_req_bridge: one instance per read latency 0..3, each
// transaction checked against expectations derived from the request itself.
module tb_aes_csr_req_bridge;

  localparam int          NI    = 4;
  localparam int          BOUND = 20;
  localparam logic [31:0] LIMIT = 32'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] req_valid, req_ready, req_write, acc_en, wr_en, rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   req_addr [NI];
  logic [31:0]   req_wdata[NI];
  logic [31:0]   addr_o   [NI];
  logic [31:0]   wdata_o  [NI];
  logic [31:0]   rdata    [NI];
  logic [31:0]   rsp_rdata[NI];

  int n_checks = 0;
  int n_fail   = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      aes_csr_req_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(gi), .ADDR_LIMIT(32'h100)
      ) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[gi]), .req_ready_o(req_ready[gi]),
        .req_write_i(req_write[gi]), .req_addr_i(req_addr[gi]), .req_wdata_i(req_wdata[gi]),
        .acc_en_o(acc_en[gi]), .wr_en_o(wr_en[gi]), .addr_o(addr_o[gi]), .wdata_o(wdata_o[gi]),
        .rdata_i(rdata[gi]),
        .rsp_valid_o(rsp_valid[gi]), .rsp_ready_i(rsp_ready[gi]),
        .rsp_rdata_o(rsp_rdata[gi]), .rsp_err_o(rsp_err[gi])
      );
    end
  endgenerate

  // One request on instance d (read latency d); entered and left at a negedge.
  task automatic run_txn(input string nm, input int d, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int hold,
                         output time acc_t);
    bit          legal, done;
    int          exp_rsp, first_rsp, acc_cnt, acc_at, ready_bad, wrq_bad, stable_bad, w;
    logic [31:0] exp_rdata;
    logic [96:0] snap;
    legal     = (a[1:0] == 2'b00) && (a < LIMIT);
    exp_rsp   = !legal ? 1 : (wr ? 2 : 2 + d);
    exp_rdata = (legal && !wr) ? rd : 32'h0;
    first_rsp = -1; acc_cnt = 0; acc_at = -1; ready_bad = 0; wrq_bad = 0; stable_bad = 0;
    done = 1'b0; snap = '0; acc_t = 0;
    req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0; rdata[d] = $urandom();
    w = 0;
    while (!req_ready[d] && w < BOUND) begin @(negedge clk); w++; end
    n_checks++;
    if (!req_ready[d]) begin
      n_fail++; $display("FAIL %s accept_timeout: req_ready=%0b required 1", nm, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    for (int k = 1; k <= BOUND && !done; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[d] = 1'b0;
      if (req_ready[d]) ready_bad++;
      if (acc_en[d]) begin
        acc_cnt++; acc_at = k;
        n_checks++;
        if ({wr_en[d], addr_o[d], wdata_o[d]} !== {wr, a, wd}) begin
          n_fail++;
          $display("FAIL %s access: wr_en=%0b addr=%h wdata=%h required %0b %h %h",
                   nm, wr_en[d], addr_o[d], wdata_o[d], wr, a, wd);
        end
      end else if (wr_en[d]) wrq_bad++;
      if (rsp_valid[d]) begin
        if (first_rsp < 0) begin
          first_rsp = k;
          snap = {rsp_rdata[d], rsp_err[d], addr_o[d], wdata_o[d]};
        end else if ({rsp_rdata[d], rsp_err[d], addr_o[d], wdata_o[d]} !== snap) stable_bad++;
        if (k - first_rsp >= hold) begin rsp_ready[d] = 1'b1; done = 1'b1; end
      end
      rdata[d] = (k == 1 + d) ? rd : $urandom();
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s rsp_timeout: no response within %0d cycles", nm, BOUND);
      return;
    end
    $display("txn %s lat=%0d wr=%0b addr=%h wdata=%h -> rsp@%0d err=%0b rdata=%h acc=%0d",
             nm, d, wr, a, wd, first_rsp, snap[64], snap[96:65], acc_cnt);
    n_checks++;
    if (acc_cnt !== (legal ? 1 : 0)) begin
      n_fail++; $display("FAIL %s acc_count: got %0d required %0d", nm, acc_cnt, legal ? 1 : 0);
    end
    n_checks++;
    if (legal && acc_at !== 1) begin
      n_fail++; $display("FAIL %s acc_cycle: got %0d required 1", nm, acc_at);
    end
    n_checks++;
    if (wrq_bad !== 0) begin
      n_fail++; $display("FAIL %s wr_en_outside_acc: %0d cycles required 0", nm, wrq_bad);
    end
    n_checks++;
    if (first_rsp !== exp_rsp) begin
      n_fail++; $display("FAIL %s rsp_cycle: got %0d required %0d", nm, first_rsp, exp_rsp);
    end
    n_checks++;
    if (snap[64] !== !legal) begin
      n_fail++; $display("FAIL %s rsp_err: got %0b required %0b", nm, snap[64], !legal);
    end
    n_checks++;
    if (snap[96:65] !== exp_rdata) begin
      n_fail++; $display("FAIL %s rsp_rdata: got %h required %h", nm, snap[96:65], exp_rdata);
    end
    n_checks++;
    if (stable_bad !== 0 || ready_bad !== 0) begin
      n_fail++; $display("FAIL %s hold: unstable=%0d ready_high=%0d required 0 0", nm, stable_bad, ready_bad);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_checks++;
    if ({rsp_valid[d], req_ready[d]} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s after_handshake: rsp_valid=%0b req_ready=%0b required 0 1", nm, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < NI; d++) begin
      n_checks++;
      if ({req_ready[d], acc_en[d], wr_en[d], addr_o[d], wdata_o[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs: instance %0d has a nonzero output, required all 0", d);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (req_ready !== '1) begin
      n_fail++; $display("FAIL reset_ready: req_ready=%b required 1111", req_ready);
    end
  endtask

  task automatic test_write();
    time t;
    run_txn("write_0x10", 1, 1'b1, 32'h10, 32'hDEADBEEF, $urandom(), 0, t);
  endtask

  task automatic test_read_lat2();
    time t;
    run_txn("read_lat2", 2, 1'b0, 32'h24, $urandom(), 32'hCAFEF00D, 0, t);
  endtask

  task automatic test_illegal();
    time t;
    run_txn("misaligned", 1, 1'b0, 32'h13, $urandom(), $urandom(), 0, t);
    run_txn("out_of_range", 1, 1'b1, 32'h100, $urandom(), $urandom(), 0, t);
    run_txn("last_legal", 3, 1'b0, 32'hFC, $urandom(), 32'h0BAD_CAFE, 0, t);
  endtask

  task automatic test_backpressure();
    time t;
    run_txn("backpressure", 1, 1'b0, 32'h0, $urandom(), 32'hA5A5_5A5A, 5, t);
  endtask

  task automatic test_lat0();
    time t;
    run_txn("read_lat0", 0, 1'b0, 32'h4, $urandom(), 32'h12345678, 0, t);
  endtask

  task automatic test_reset_mid_wait();
    time t;
    int  late_bad;
    req_write[3] = 1'b0; req_addr[3] = 32'h20; req_wdata[3] = '0; req_valid[3] = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid[3] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready[3], acc_en[3], wr_en[3], addr_o[3], wdata_o[3], rsp_valid[3], rsp_rdata[3], rsp_err[3]} !== '0) begin
      n_fail++; $display("FAIL reset_mid_wait: outputs nonzero after async reset, required all 0");
    end
    @(negedge clk); rst_n = 1'b1;
    late_bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid[3] || acc_en[3]) late_bad++;
    end
    n_checks++;
    if (late_bad !== 0) begin
      n_fail++; $display("FAIL reset_no_response: %0d cycles with rsp_valid/acc_en, required 0", late_bad);
    end
    run_txn("after_reset", 3, 1'b0, 32'h8, $urandom(), 32'h7777_1234, 0, t);
  endtask

  task automatic test_back_to_back();
    time t_prev, t_cur;
    run_txn("b2b_0", 0, 1'b1, 32'h40, $urandom(), $urandom(), 0, t_prev);
    for (int i = 1; i < 4; i++) begin
      run_txn($sformatf("b2b_%0d", i), 0, 1'b1, 32'h40 + 32'(4 * i), $urandom(), $urandom(), 0, t_cur);
      n_checks++;
      if (t_cur - t_prev !== 30) begin
        n_fail++; $display("FAIL b2b_spacing: got %0t required 30", t_cur - t_prev);
      end
      t_prev = t_cur;
    end
  endtask

  task automatic test_random();
    time         t;
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1:    a = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        2:       a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        default: a = 32'($urandom_range(32'h100, 32'hFFFF));
      endcase
      run_txn($sformatf("rand_%0d", i), $urandom_range(0, NI - 1), 1'($urandom_range(0, 1)),
              a, $urandom(), $urandom(), $urandom_range(0, 3), t);
    end
  endtask

  initial begin
    req_valid = '0; req_write = '0; rsp_ready = '0;
    for (int d = 0; d < NI; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; rdata[d] = '0;
    end
    #2;
    test_reset();
    test_write();
    test_read_lat2();
    test_illegal();
    test_backpressure();
    test_reset_mid_wait();
    test_lat0();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
